// File: rtl/vai_pkg.sv
// Shared definitions for the VAI Tx request path: default sizing, a
// constant-foldable clog2 and the per-instance status bundle the mux collects.
package vai_pkg;

    localparam int unsigned VAI_TX_DEPTH_DEFAULT    = 64;
    localparam int unsigned VAI_TX_AF_SLACK_DEFAULT = 8;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned vai_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int unsigned VAI_TX_FILL_W = vai_clog2(VAI_TX_DEPTH_DEFAULT + 1);

    typedef struct packed {
        logic [VAI_TX_FILL_W-1:0] fill_level;
        logic                     overflow;
        logic [31:0]              tx_count;
    } t_vai_tx_stats;

endpackage

// File: rtl/vai_sync_fifo.sv
// Single-clock FIFO: inferred RAM, wrapping pointers, occupancy count and a
// registered read port loaded only when rd_en is asserted.
module vai_sync_fifo
    import vai_pkg::*;
#(
    parameter int unsigned WIDTH = 600,
    parameter int unsigned DEPTH = VAI_TX_DEPTH_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [WIDTH-1:0]                wr_data,
    input  logic                            rd_en,
    output logic [WIDTH-1:0]                rd_data,
    output logic [vai_clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = vai_clog2(DEPTH);
    localparam int unsigned CNT_W = vai_clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Next pointers, occupancy and read-port value.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
        count_d   = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        rd_data_d = rd_en ? mem[rd_ptr_q] : rd_data_q;
    end

    // Storage array; no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer, count and read-register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign count   = count_q;

endmodule

// File: rtl/vai_tx_buffer.sv
// Per-sub-AFU Tx request elastic buffer in front of one vai_mux port.
// Absorbs requests issued after almost-full and re-issues one per cycle
// while the mux side is not almost-full.
module vai_tx_buffer
    import vai_pkg::*;
#(
    parameter int unsigned WIDTH    = 600,
    parameter int unsigned DEPTH    = VAI_TX_DEPTH_DEFAULT,
    parameter int unsigned AF_SLACK = VAI_TX_AF_SLACK_DEFAULT
) (
    input  logic                          pClk,
    input  logic                          pck_cp2af_softReset_n,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_almFull,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_almFull,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level,
    output logic                          overflow,
    output logic [31:0]                   tx_count
);

    localparam int unsigned     FILL_W   = vai_clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] AF_LVL   = FILL_W'(DEPTH - AF_SLACK);

    logic [FILL_W-1:0] count;
    logic [FILL_W-1:0] fill_next;
    logic              full;
    logic              pop;
    logic              push;

    logic        in_almfull_q, in_almfull_d;
    logic        out_valid_q,  out_valid_d;
    logic        overflow_q,   overflow_d;
    logic [31:0] tx_count_q,   tx_count_d;

    // Push/pop decisions, next occupancy and status next-state.
    // At full with a pop, wr_ptr equals rd_ptr: the registered read samples
    // the old head before the new write lands, so both may proceed together.
    always_comb begin
        full       = (count == FULL_LVL);
        pop        = !out_almFull && (count != '0);
        push       = in_valid && (!full || pop);
        fill_next  = count;
        if (push && !pop) begin
            fill_next = count + FILL_W'(1);
        end else if (pop && !push) begin
            fill_next = count - FILL_W'(1);
        end
        in_almfull_d = (fill_next >= AF_LVL);
        out_valid_d  = pop;
        overflow_d   = overflow_q || (in_valid && full && !pop);
        tx_count_d   = tx_count_q + 32'(out_valid_q);
    end

    // Status and handshake registers.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            in_almfull_q <= 1'b1;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            tx_count_q   <= '0;
        end else begin
            in_almfull_q <= in_almfull_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            tx_count_q   <= tx_count_d;
        end
    end

    vai_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (pClk),
        .rst_n   (pck_cp2af_softReset_n),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (out_data),
        .count   (count)
    );

    assign in_almFull = in_almfull_q;
    assign out_valid  = out_valid_q;
    assign fill_level = count;
    assign overflow   = overflow_q;
    assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_vai_tx_buffer.sv
// Self-checking bench for vai_tx_buffer: scoreboard of expected payloads
// consumed by an output monitor, plus per-scenario inline checks.
module tb_vai_tx_buffer;

    localparam int unsigned WIDTH    = 600;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned AF_SLACK = 8;
    localparam int unsigned FILL_W   = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_almFull;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_almFull;
    logic [FILL_W-1:0] fill_level;
    logic              overflow;
    logic [31:0]       tx_count;

    int checks = 0;
    int errors = 0;
    int beats  = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mon_exp;

    vai_tx_buffer #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_SLACK (AF_SLACK)
    ) dut (
        .pClk                  (clk),
        .pck_cp2af_softReset_n (rst_n),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_almFull            (in_almFull),
        .out_valid             (out_valid),
        .out_data              (out_data),
        .out_almFull           (out_almFull),
        .fill_level            (fill_level),
        .overflow              (overflow),
        .tx_count              (tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output monitor: every beat must match the oldest expected payload.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            beats  = beats + 1;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_beat: out_data=%0h, required no beat", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    errors = errors + 1;
                    $display("FAIL beat_data: out_data=%0h, required %0h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_almFull = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks = checks + 1;
            if (in_almFull !== 1'b1 || out_valid !== 1'b0 || fill_level !== '0 ||
                overflow !== 1'b0 || tx_count !== 32'd0 || out_data !== '0) begin
                errors = errors + 1;
                $display("FAIL reset_values: almF=%b ov=%b fill=%0d ovf=%b txc=%0d, required 1 0 0 0 0",
                         in_almFull, out_valid, fill_level, overflow, tx_count);
            end
        end
        rst_n = 1'b1;
        cyc();
        checks = checks + 1;
        if (in_almFull !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL release_almfull: in_almFull=%b, required 0", in_almFull);
        end
    endtask

    task automatic test_pass_through();
        int max_fill = 0;
        out_almFull = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            exp_q.push_back(WIDTH'(i));
            cyc();
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
            checks = checks + 1;
            if (out_valid !== (i >= 2)) begin
                errors = errors + 1;
                $display("FAIL pass_valid_%0d: out_valid=%b, required %b", i, out_valid, (i >= 2));
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        cyc();
        checks = checks + 1;
        if (out_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL pass_last_beat: out_valid=%b, required 1", out_valid);
        end
        cyc();
        checks = checks + 1;
        if (out_valid !== 1'b0 || tx_count !== 32'd10 || fill_level !== '0) begin
            errors = errors + 1;
            $display("FAIL pass_end: out_valid=%b tx_count=%0d fill=%0d, required 0 10 0",
                     out_valid, tx_count, fill_level);
        end
        checks = checks + 1;
        if (max_fill > 2 || exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pass_fill_peak: peak=%0d pending=%0d, required <=2 and 0",
                     max_fill, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        out_almFull = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(100 + k);
            exp_q.push_back(WIDTH'(100 + k));
            cyc();
            if (k == 55) begin
                checks = checks + 1;
                if (in_almFull !== 1'b0) begin
                    errors = errors + 1;
                    $display("FAIL almfull_early: in_almFull=%b at fill %0d, required 0", in_almFull, fill_level);
                end
            end
            if (k == 56) begin
                checks = checks + 1;
                if (in_almFull !== 1'b1 || fill_level !== FILL_W'(56)) begin
                    errors = errors + 1;
                    $display("FAIL almfull_assert: in_almFull=%b fill=%0d, required 1 56", in_almFull, fill_level);
                end
            end
            if (k == 63 || k == 64) begin
                checks = checks + 1;
                if (fill_level !== FILL_W'(k) || overflow !== 1'b0) begin
                    errors = errors + 1;
                    $display("FAIL fill_%0d: fill=%0d overflow=%b, required %0d 0", k, fill_level, overflow, k);
                end
            end
        end
        in_data = WIDTH'(999000);
        cyc();
        in_valid = 1'b0;
        checks = checks + 1;
        if (fill_level !== FILL_W'(64) || overflow !== 1'b1 || out_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL drop_on_full: fill=%0d overflow=%b out_valid=%b, required 64 1 0",
                     fill_level, overflow, out_valid);
        end
        cyc();
        checks = checks + 1;
        if (overflow !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL overflow_sticky: overflow=%b, required 1", overflow);
        end
    endtask

    task automatic test_drain();
        int b0 = beats;
        out_almFull = 1'b0;
        repeat (20) cyc();
        out_almFull = 1'b1;
        checks = checks + 1;
        if (fill_level !== FILL_W'(44) || in_almFull !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL drain_level: fill=%0d in_almFull=%b, required 44 0", fill_level, in_almFull);
        end
        cyc();
        cyc();
        checks = checks + 1;
        if (beats - b0 != 20 || fill_level !== FILL_W'(44) || exp_q.size() != 44) begin
            errors = errors + 1;
            $display("FAIL drain_beats: beats=%0d fill=%0d pending=%0d, required 20 44 44",
                     beats - b0, fill_level, exp_q.size());
        end
    endtask

    task automatic test_full_simul();
        apply_reset();
        out_almFull = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(300 + k);
            exp_q.push_back(WIDTH'(300 + k));
            cyc();
        end
        in_valid = 1'b0;
        checks = checks + 1;
        if (fill_level !== FILL_W'(64) || overflow !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL simul_prefill: fill=%0d overflow=%b, required 64 0", fill_level, overflow);
        end
        out_almFull = 1'b0;
        in_valid    = 1'b1;
        in_data     = WIDTH'(777);
        exp_q.push_back(WIDTH'(777));
        cyc();
        in_valid = 1'b0;
        checks = checks + 1;
        if (fill_level !== FILL_W'(64) || overflow !== 1'b0 || out_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL simul_push_pop: fill=%0d overflow=%b out_valid=%b, required 64 0 1",
                     fill_level, overflow, out_valid);
        end
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0 && out_valid !== 1'b1) break;
            cyc();
        end
        checks = checks + 1;
        if (exp_q.size() != 0 || fill_level !== '0) begin
            errors = errors + 1;
            $display("FAIL simul_drain_timeout: pending=%0d fill=%0d, required 0 0", exp_q.size(), fill_level);
        end
    endtask

    task automatic test_reset_midstream();
        out_almFull = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(500 + k);
            exp_q.push_back(WIDTH'(500 + k));
            cyc();
        end
        in_valid    = 1'b0;
        out_almFull = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (fill_level == FILL_W'(30)) break;
        end
        checks = checks + 1;
        if (fill_level !== FILL_W'(30) || out_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL midstream_setup: fill=%0d out_valid=%b, required 30 1", fill_level, out_valid);
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks = checks + 1;
        if (out_valid !== 1'b0 || fill_level !== '0 || in_almFull !== 1'b1 ||
            tx_count !== 32'd0 || out_data !== '0) begin
            errors = errors + 1;
            $display("FAIL async_reset: out_valid=%b fill=%0d almF=%b txc=%0d, required 0 0 1 0",
                     out_valid, fill_level, in_almFull, tx_count);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc();
            checks = checks + 1;
            if (out_valid !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL stale_beat_%0d: out_valid=%b, required 0", n, out_valid);
            end
        end
        checks = checks + 1;
        if (tx_count !== 32'd0 || fill_level !== '0) begin
            errors = errors + 1;
            $display("FAIL post_reset_state: tx_count=%0d fill=%0d, required 0 0", tx_count, fill_level);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_drain();
        test_full_simul();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
